// File: rtl/car_alarm_pkg.sv
// Shared types and timing defaults for the car alarm siren controller.
// Optional feature macro: CAR_ALARM_BEEP_PATTERN_EN (pulsed siren).
package car_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRACE   = 2'd1,
    SIREN   = 2'd2,
    LOCKOUT = 2'd3
  } alarm_state_t;

  localparam int GRACE_CYCLES_DEF     = 8;
  localparam int BEEP_HALF_PERIOD_DEF = 4;
  localparam int SIREN_TIMEOUT_DEF    = 64;
  localparam int CNT_W_DEF            = 8;

endpackage

// File: rtl/car_alarm_beep_gen.sv
// Siren level generator driven by the SIREN phase counter.
// CAR_ALARM_BEEP_PATTERN_EN selects pulsed output; otherwise steady on.
module car_alarm_beep_gen
  import car_alarm_pkg::*;
#(
  parameter int BEEP_HALF_PERIOD = BEEP_HALF_PERIOD_DEF,
  parameter int CNT_W            = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_en,
  output logic             o_siren
);

`ifdef CAR_ALARM_BEEP_PATTERN_EN
  logic [CNT_W-1:0] w_phase;

  // Even half-periods are the audible phase.
  assign w_phase = i_cnt / CNT_W'(BEEP_HALF_PERIOD);
  assign o_siren = i_en & ~w_phase[0];
`else
  logic w_unused;

  assign w_unused = ^i_cnt;
  assign o_siren  = i_en;
`endif

endmodule

// File: rtl/car_alarm_siren_ctrl.sv
// Alarm sequencer: grace window, bounded siren, lockout until condition clears.
// Optional feature macro: CAR_ALARM_BEEP_PATTERN_EN (pulsed siren).
module car_alarm_siren_ctrl
  import car_alarm_pkg::*;
#(
  parameter int GRACE_CYCLES     = GRACE_CYCLES_DEF,
  parameter int BEEP_HALF_PERIOD = BEEP_HALF_PERIOD_DEF,
  parameter int SIREN_TIMEOUT    = SIREN_TIMEOUT_DEF,
  parameter int CNT_W            = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CarAlarmSignal,
  input  logic       AcknowledgeBtn,
  output logic       SirenOut,
  output logic       WarningLed,
  output logic       AlarmActive,
  output logic [1:0] AlarmState
);

  localparam logic [CNT_W-1:0] GRACE_LAST = CNT_W'(GRACE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIREN_LAST = CNT_W'(SIREN_TIMEOUT - 1);

  alarm_state_t     r_state;
  alarm_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_siren;
  logic             r_led;
  logic             r_active;
  logic             w_beep;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (CarAlarmSignal) begin
          w_state_nxt = GRACE;
          w_cnt_nxt   = '0;
        end
      end
      GRACE: begin
        if (AcknowledgeBtn) begin
          w_state_nxt = LOCKOUT;
        end else if (!CarAlarmSignal) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == GRACE_LAST) begin
          w_state_nxt = SIREN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      SIREN: begin
        // Condition is latched here; only ack or timeout ends the siren.
        if (AcknowledgeBtn || (r_cnt == SIREN_LAST)) begin
          w_state_nxt = LOCKOUT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      LOCKOUT: begin
        if (!CarAlarmSignal) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  car_alarm_beep_gen #(
    .BEEP_HALF_PERIOD (BEEP_HALF_PERIOD),
    .CNT_W            (CNT_W)
  ) u_beep (
    .i_cnt   (w_cnt_nxt),
    .i_en    (w_state_nxt == SIREN),
    .o_siren (w_beep)
  );

  // Outputs track next state so they switch on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_siren  <= 1'b0;
      r_led    <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_siren  <= w_beep;
      r_led    <= (w_state_nxt == GRACE);
      r_active <= (w_state_nxt == SIREN);
    end
  end

  assign SirenOut    = r_siren;
  assign WarningLed  = r_led;
  assign AlarmActive = r_active;
  assign AlarmState  = r_state;

endmodule

// File: tb/tb_car_alarm_siren_ctrl.sv
// Directed self-checking bench for car_alarm_siren_ctrl.
// Expectations follow CAR_ALARM_BEEP_PATTERN_EN when it is defined.
module tb_car_alarm_siren_ctrl;

  localparam int G = 8;
  localparam int H = 4;
  localparam int T = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alarm = 1'b0;
  logic       ack = 1'b0;
  logic       siren;
  logic       led;
  logic       active;
  logic [1:0] st;

  int total = 0;
  int bad = 0;

  car_alarm_siren_ctrl #(
    .GRACE_CYCLES     (G),
    .BEEP_HALF_PERIOD (H),
    .SIREN_TIMEOUT    (T),
    .CNT_W            (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .CarAlarmSignal (alarm),
    .AcknowledgeBtn (ack),
    .SirenOut       (siren),
    .WarningLed     (led),
    .AlarmActive    (active),
    .AlarmState     (st)
  );

  always #5 clk = ~clk;

  wire [4:0] obs = {st, led, active, siren};

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", obs, 5'b00000);
    end
    reset = 1'b0;
    cyc(2);
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("FAIL idle_hold got=%b exp=%b", obs, 5'b00000);
    end
  endtask

  task automatic test_full_sequence;
    logic [1:0] es;
    logic       ep;
    logic [4:0] exp;
    alarm = 1'b1;
    for (int k = 0; k < G + T + 4; k++) begin
      @(negedge clk);
      es = (k < G) ? 2'd1 : (k < G + T) ? 2'd2 : 2'd3;
`ifdef CAR_ALARM_BEEP_PATTERN_EN
      ep = (es == 2'd2) && ((((k - G) / H) % 2) == 0);
`else
      ep = (es == 2'd2);
`endif
      exp = {es, es == 2'd1, es == 2'd2, ep};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL full_seq k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    alarm = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("FAIL full_release got=%b exp=%b", obs, 5'b00000);
    end
  endtask

  task automatic test_grace_abort;
    alarm = 1'b1;
    cyc(4);
    total++;
    if (obs !== 5'b01100) begin
      bad++;
      $display("FAIL abort_grace got=%b exp=%b", obs, 5'b01100);
    end
    alarm = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      total++;
      if (obs !== 5'b00000) begin
        bad++;
        $display("FAIL abort_idle k=%0d got=%b exp=%b", k, obs, 5'b00000);
      end
    end
  endtask

  task automatic test_ack_siren;
    alarm = 1'b1;
    cyc(G + 10);
    total++;
    if (st !== 2'd2) begin
      bad++;
      $display("FAIL ack10_pre got=%0d exp=%0d", st, 2);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    total++;
    if (obs !== 5'b11000) begin
      bad++;
      $display("FAIL ack10_lock got=%b exp=%b", obs, 5'b11000);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (obs !== 5'b11000) begin
        bad++;
        $display("FAIL ack10_hold k=%0d got=%b exp=%b", k, obs, 5'b11000);
      end
    end
    alarm = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("FAIL ack10_idle got=%b exp=%b", obs, 5'b00000);
    end
    alarm = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== 5'b01100) begin
      bad++;
      $display("FAIL rearm got=%b exp=%b", obs, 5'b01100);
    end
    alarm = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ack_expiry;
    alarm = 1'b1;
    cyc(G);
    total++;
    if (obs !== 5'b01100) begin
      bad++;
      $display("FAIL expiry_pre got=%b exp=%b", obs, 5'b01100);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs !== 5'b11000) begin
        bad++;
        $display("FAIL expiry_lock k=%0d got=%b exp=%b", k, obs, 5'b11000);
      end
      @(negedge clk);
    end
    alarm = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("FAIL expiry_idle got=%b exp=%b", obs, 5'b00000);
    end
  endtask

  task automatic test_ack_timeout;
    alarm = 1'b1;
    cyc(G + T);
    total++;
    if (st !== 2'd2) begin
      bad++;
      $display("FAIL timeout_pre got=%0d exp=%0d", st, 2);
    end
    ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (obs !== 5'b11000) begin
        bad++;
        $display("FAIL timeout_lock k=%0d got=%b exp=%b", k, obs, 5'b11000);
      end
    end
    alarm = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("FAIL timeout_idle got=%b exp=%b", obs, 5'b00000);
    end
  endtask

  task automatic test_reset_mid_siren;
    alarm = 1'b1;
    cyc(G + 2);
    total++;
    if (obs !== 5'b10011) begin
      bad++;
      $display("FAIL rst_pre got=%b exp=%b", obs, 5'b10011);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("FAIL rst_async got=%b exp=%b", obs, 5'b00000);
    end
    alarm = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("FAIL rst_release got=%b exp=%b", obs, 5'b00000);
    end
    @(negedge clk);
    total++;
    if (obs !== 5'b00000) begin
      bad++;
      $display("FAIL rst_idle got=%b exp=%b", obs, 5'b00000);
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_grace_abort();
    test_ack_siren();
    test_ack_expiry();
    test_ack_timeout();
    test_reset_mid_siren();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
